// File: rtl/pulse_stretch_if.sv
// rtl/pulse_stretch_if.sv - trigger/len request side and stretched-pulse status of pulse_stretch
interface pulse_stretch_if #(
    parameter int LEN_W  = 8,
    parameter int PEND_W = 2
);
    logic              trigger;
    logic [LEN_W-1:0]  len;
    logic              retrigger_en;
    logic              out;
    logic              busy;
    logic              done;
    logic [PEND_W-1:0] pending;
    logic              dropped;

    modport master (
        output trigger, len, retrigger_en,
        input  out, busy, done, pending, dropped
    );

    modport slave (
        input  trigger, len, retrigger_en,
        output out, busy, done, pending, dropped
    );
endinterface

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches one-cycle triggers into programmable-length pulses with a min low gap
module pulse_stretch #(
    parameter int LEN_W  = 8,
    parameter int GAP    = 2,
    parameter int PEND_W = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pulse_stretch_if.slave ps_io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [7:0]        GAP_INIT = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        gap_q, gap_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              drop_q, drop_d;

    logic [LEN_W-1:0]  load_cnt;
    logic              inc, dec, inc_eff, sat;

    // len==0 behaves as len==1, so both load a count of zero
    assign load_cnt = (ps_io.len == '0) ? '0 : ps_io.len - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        inc     = ps_io.trigger;
        dec     = 1'b0;
        case (state_q)
            S_IDLE: begin
                inc = 1'b0;
                if (ps_io.trigger) begin
                    state_d = S_HIGH;
                    cnt_d   = load_cnt;
                end
            end
            S_HIGH: begin
                if (ps_io.trigger && ps_io.retrigger_en) begin
                    inc   = 1'b0;
                    cnt_d = load_cnt;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_INIT;
                end else if (pend_q != '0 || ps_io.trigger) begin
                    cnt_d = load_cnt;
                    dec   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (pend_q != '0 || ps_io.trigger) begin
                    // a same-cycle trigger counts as inc, so starting from it leaves pending unchanged
                    state_d = S_HIGH;
                    cnt_d   = load_cnt;
                    dec     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sat     = (pend_q == PEND_MAX);
    assign inc_eff = inc && !(sat && !dec);
    assign drop_d  = inc && sat && !dec;
    assign pend_d  = pend_q + PEND_W'(inc_eff) - PEND_W'(dec);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    assign ps_io.out     = (state_q == S_HIGH);
    assign ps_io.busy    = (state_q != S_IDLE);
    assign ps_io.done    = (state_q == S_HIGH) && (cnt_q == '0);
    assign ps_io.pending = pend_q;
    assign ps_io.dropped = drop_q;
endmodule
